// File: rtl/dsp_dot_sequencer.sv
// Operand sequencer for the 8x8+20 MAC BEL: streams operand pairs into the MAC and returns one dot product per job.
// Optional accumulator-wrap detection is compiled in with `define DOT_SEQ_OVF_EN.
module dsp_dot_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic              UserCLK,
  input  logic              clr,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  output logic [DATA_W-1:0] mac_A,
  output logic [DATA_W-1:0] mac_B,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  mac_Q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_result,
  output logic              m_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_CAPTURE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] mac_a_q, mac_a_d;
  logic [DATA_W-1:0] mac_b_q, mac_b_d;
  logic [ACC_W-1:0]  m_result_q, m_result_d;
  logic              accept;

  assign accept = s_valid && (state_q == S_RUN);

  always_ff @(posedge UserCLK) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (cfg_len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:   state_d = S_RUN;
      S_RUN:     if (accept && remaining_q == LEN_W'(1)) state_d = S_FLUSH;
      S_FLUSH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    if (m_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    s_ready = (state_q == S_RUN);
    m_valid = (state_q == S_DONE);
    mac_clr = clr || (state_q == S_CLEAR);
  end

  // Operands are zero outside accepted beats so bubbles add nothing; FLUSH keeps the last beat one extra cycle.
  always_comb begin
    remaining_d = remaining_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    m_result_d  = m_result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = cfg_len;
          if (cfg_len == '0) m_result_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          mac_a_d     = s_a;
          mac_b_d     = s_b;
          remaining_d = remaining_q - LEN_W'(1);
        end
      end
      S_CAPTURE: m_result_d = mac_Q;
      default: ;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (clr) begin
      remaining_q <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      m_result_q  <= '0;
    end else begin
      remaining_q <= remaining_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      m_result_q  <= m_result_d;
    end
  end

  assign mac_A    = mac_a_q;
  assign mac_B    = mac_b_q;
  assign m_result = m_result_q;

`ifdef DOT_SEQ_OVF_EN
  logic [ACC_W-1:0] prev_q, prev_d;
  logic             m_overflow_q, m_overflow_d;

  // A product never exceeds one wrap, so a decrease in the accumulator means it wrapped.
  function automatic logic acc_wrapped(input logic [ACC_W-1:0] cur, input logic [ACC_W-1:0] prev);
    return (cur < prev);
  endfunction

  always_comb begin
    prev_d       = prev_q;
    m_overflow_d = m_overflow_q;
    case (state_q)
      S_IDLE:  if (start && cfg_len == '0) m_overflow_d = 1'b0;
      S_CLEAR: begin
        prev_d       = '0;
        m_overflow_d = 1'b0;
      end
      S_RUN, S_FLUSH, S_CAPTURE: begin
        prev_d = mac_Q;
        if (acc_wrapped(mac_Q, prev_q)) m_overflow_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    prev_q <= prev_d;
    if (clr) m_overflow_q <= 1'b0;
    else     m_overflow_q <= m_overflow_d;
  end

  assign m_overflow = m_overflow_q;
`else
  assign m_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_dot_sequencer.sv
// Bench for dsp_dot_sequencer with a behavioural model of the accumulate-mode MAC BEL.
// Expected results go into a scoreboard queue; a monitor checks each result as m_valid rises.
module tb_dsp_dot_sequencer;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 8;
`ifdef DOT_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              UserCLK = 1'b0;
  logic              clr, start, s_valid, m_ready;
  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] s_a, s_b;
  logic              busy, s_ready, mac_clr, m_valid, m_overflow;
  logic [DATA_W-1:0] mac_A, mac_B;
  logic [ACC_W-1:0]  mac_Q, m_result;

  dsp_dot_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .UserCLK(UserCLK), .clr(clr), .start(start), .cfg_len(cfg_len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .mac_A(mac_A), .mac_B(mac_B), .mac_clr(mac_clr), .mac_Q(mac_Q),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_overflow(m_overflow)
  );

  always #5 UserCLK = ~UserCLK;

  // MAC BEL: unregistered A/B, unsigned, accumulate into ACC, Q = ACC
  logic [ACC_W-1:0] acc;
  logic [15:0]      prod;
  assign prod  = mac_A * mac_B;
  assign mac_Q = acc;
  always @(posedge UserCLK) begin
    if (mac_clr) acc <= '0;
    else         acc <= acc + {4'd0, prod};
  end

  typedef struct packed {
    logic [ACC_W-1:0] res;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_seen = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ACC_W-1:0] res, input logic ovf);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge UserCLK);
      if (m_valid && !mon_seen) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d, expected no result", m_result);
        end else begin
          mon_e = sb_q.pop_front();
          check("m_result", 32'(m_result), 32'(mon_e.res));
          check("m_overflow", 32'(m_overflow), 32'(mon_e.ovf));
        end
      end
      mon_seen = m_valid;
    end
  end

  task automatic start_job(input logic [LEN_W-1:0] len);
    start   = 1'b1;
    cfg_len = len;
    @(negedge UserCLK);
    start   = 1'b0;
    cfg_len = '0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int t;
    t       = 0;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    while (!s_ready && t < 50) begin
      @(negedge UserCLK);
      t++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_timeout: got s_ready=0, expected s_ready=1 within 50 cycles");
    end
    @(negedge UserCLK);
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
  endtask

  task automatic wait_valid(input int max_cyc);
    int t;
    t = 0;
    while (!m_valid && t < max_cyc) begin
      @(negedge UserCLK);
      t++;
    end
    if (!m_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL result_timeout: got m_valid=0, expected m_valid=1 within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_result(input int max_cyc);
    wait_valid(max_cyc);
    m_ready = 1'b1;
    @(negedge UserCLK);
    m_ready = 1'b0;
    check("idle_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1; start = 1'b0; cfg_len = '0;
    s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;

    // Reset state
    @(negedge UserCLK);
    @(negedge UserCLK);
    check("rst_mac_clr", 32'(mac_clr), 32'd1);
    clr = 1'b0;
    @(negedge UserCLK);
    check("rst_mac_A", 32'(mac_A), 32'd0);
    check("rst_mac_B", 32'(mac_B), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_result", 32'(m_result), 32'd0);
    check("rst_m_overflow", 32'(m_overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("idle_mac_clr", 32'(mac_clr), 32'd0);

    // Basic job: 2*3 + 4*5 + 10*10 = 126
    push_exp(20'd126, 1'b0);
    start_job(8'd3);
    check("clear_s_ready", 32'(s_ready), 32'd0);
    check("clear_mac_clr", 32'(mac_clr), 32'd1);
    check("clear_busy", 32'(busy), 32'd1);
    beat(8'd2, 8'd3);
    beat(8'd4, 8'd5);
    beat(8'd10, 8'd10);
    check("lat_flush_valid", 32'(m_valid), 32'd0);
    check("lat_flush_s_ready", 32'(s_ready), 32'd0);
    @(negedge UserCLK);
    check("lat_capture_valid", 32'(m_valid), 32'd0);
    @(negedge UserCLK);
    check("lat_done_valid", 32'(m_valid), 32'd1);
    wait_result(5);

    // Source bubbles: two idle cycles after each of the first two beats
    push_exp(20'd126, 1'b0);
    start_job(8'd3);
    beat(8'd2, 8'd3);
    @(negedge UserCLK);
    check("gap1_mac_A", 32'(mac_A), 32'd0);
    check("gap1_mac_B", 32'(mac_B), 32'd0);
    check("gap1_mac_Q", 32'(mac_Q), 32'd6);
    @(negedge UserCLK);
    check("gap1_hold_mac_A", 32'(mac_A), 32'd0);
    check("gap1_hold_mac_Q", 32'(mac_Q), 32'd6);
    beat(8'd4, 8'd5);
    @(negedge UserCLK);
    check("gap2_mac_A", 32'(mac_A), 32'd0);
    check("gap2_mac_Q", 32'(mac_Q), 32'd26);
    @(negedge UserCLK);
    check("gap2_hold_mac_Q", 32'(mac_Q), 32'd26);
    beat(8'd10, 8'd10);
    wait_result(10);

    // Wrap boundary: 16*65025 fits, 17*65025 wraps to 56849
    push_exp(20'd1040400, 1'b0);
    start_job(8'd16);
    for (int i = 0; i < 16; i++) beat(8'd255, 8'd255);
    wait_result(10);
    push_exp(20'd56849, OVF_EN);
    start_job(8'd17);
    for (int i = 0; i < 17; i++) beat(8'd255, 8'd255);
    wait_result(10);

    // Zero-length job, then back-to-back job must start from a cleared accumulator
    push_exp(20'd0, 1'b0);
    start_job(8'd0);
    check("zero_len_done", 32'(m_valid), 32'd1);
    check("zero_len_result", 32'(m_result), 32'd0);
    wait_result(3);
    push_exp(20'd2, 1'b0);
    start_job(8'd2);
    beat(8'd1, 8'd1);
    beat(8'd1, 8'd1);
    wait_result(10);

    // Result backpressure with start pulsed while in DONE
    push_exp(20'd12, 1'b0);
    start_job(8'd1);
    beat(8'd3, 8'd4);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      cfg_len = 8'd5;
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_m_result", 32'(m_result), 32'd12);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      @(negedge UserCLK);
    end
    start   = 1'b0;
    cfg_len = '0;
    m_ready = 1'b1;
    @(negedge UserCLK);
    m_ready = 1'b0;
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_valid", 32'(m_valid), 32'd0);
    @(negedge UserCLK);
    check("bp_no_restart", 32'(busy), 32'd0);

    // Reset mid-job abandons the job with no result
    start_job(8'd4);
    beat(8'd1, 8'd2);
    beat(8'd3, 8'd4);
    clr = 1'b1;
    @(negedge UserCLK);
    check("midrst_mac_clr", 32'(mac_clr), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_mac_A", 32'(mac_A), 32'd0);
    clr = 1'b0;
    @(negedge UserCLK);
    check("midrst_release_mac_clr", 32'(mac_clr), 32'd0);
    push_exp(20'd9, 1'b0);
    start_job(8'd1);
    beat(8'd3, 8'd3);
    wait_result(10);

    repeat (3) @(negedge UserCLK);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
